morra_match_driver: RTL

- Automated two-player initiator for the MorraCinese game FSMD.
- Opens a match by pulsing INIZIA with the max-manche code, then drives one pseudo-random move pair per clock on PRIMO/SECONDO.
- Consumes MANCHE/PARTITA, keeps per-match tallies and reports the final result.
- Used as on-chip stimulus/soak source and as bench traffic generator for the game FSMD.

---
 rtl/morra_match_driver.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/morra_match_driver.sv
`default_nettype none
// ============================================================================
// Module   : morra_match_driver
// Brief    : Two-player initiator for the MorraCinese game FSMD; opens a
//            match, drives LFSR move pairs, tallies rounds, reports result.
// Revision : 1.0
// ============================================================================
module morra_match_driver #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter bit          INVALID_EN = 1'b1,
    parameter bit          RULE_EN    = 1'b1,
    parameter int          MAX_ROUNDS = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] max_code,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIA,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [1:0] match_result,
    output logic [4:0] wins1,
    output logic [4:0] wins2,
    output logic [4:0] draws,
    output logic [4:0] invalid
);

    localparam logic [4:0]  C_LAST_ROUND = 5'(MAX_ROUNDS - 1);
    localparam logic [4:0]  C_SAT        = 5'd31;
    localparam logic [15:0] C_TAPS       = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [1:0]  r_forb1, r_forb2;
    logic [4:0]  r_round;
    logic [4:0]  r_wins1, r_wins2, r_draws, r_invalid;
    logic [1:0]  r_result;
    logic        r_timeout, r_done, r_inizia, r_busy;

    logic [15:0] w_lfsr_nxt;
    logic [1:0]  w_mv1, w_mv2;

    // Optional 00->01 remap, then bump a repeated winning move to the next valid one.
    function automatic logic [1:0] f_move(input logic [1:0] raw, input logic [1:0] forb);
        logic [1:0] m;
        m = raw;
        if (!INVALID_EN && m == 2'b00) m = 2'b01;
        if (RULE_EN && m != 2'b00 && m == forb) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
        return m;
    endfunction

    assign w_lfsr_nxt = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ C_TAPS) : {1'b0, r_lfsr[15:1]};
    assign w_mv1      = f_move(r_lfsr[1:0], r_forb1);
    assign w_mv2      = f_move(r_lfsr[3:2], r_forb2);

    always_comb begin
        PRIMO   = 2'b00;
        SECONDO = 2'b00;
        if (r_state == S_START) begin
            PRIMO   = max_code[3:2];
            SECONDO = max_code[1:0];
        end else if (r_state == S_PLAY) begin
            PRIMO   = w_mv1;
            SECONDO = w_mv2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= SEED;
            r_forb1   <= 2'b00;
            r_forb2   <= 2'b00;
            r_round   <= 5'd0;
            r_wins1   <= 5'd0;
            r_wins2   <= 5'd0;
            r_draws   <= 5'd0;
            r_invalid <= 5'd0;
            r_result  <= 2'b00;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
            r_inizia  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_START;
                        r_inizia  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_round   <= 5'd0;
                        r_wins1   <= 5'd0;
                        r_wins2   <= 5'd0;
                        r_draws   <= 5'd0;
                        r_invalid <= 5'd0;
                        r_result  <= 2'b00;
                        r_timeout <= 1'b0;
                    end
                end
                S_START: begin
                    r_inizia <= 1'b0;
                    r_state  <= S_PLAY;
                end
                S_PLAY: begin
                    r_lfsr  <= w_lfsr_nxt;
                    r_round <= r_round + 5'd1;
                    case (MANCHE)
                        2'b01: begin
                            if (r_wins1 != C_SAT) r_wins1 <= r_wins1 + 5'd1;
                            r_forb1 <= w_mv1;
                            r_forb2 <= 2'b00;
                        end
                        2'b10: begin
                            if (r_wins2 != C_SAT) r_wins2 <= r_wins2 + 5'd1;
                            r_forb2 <= w_mv2;
                            r_forb1 <= 2'b00;
                        end
                        2'b11: begin
                            if (r_draws != C_SAT) r_draws <= r_draws + 5'd1;
                            r_forb1 <= 2'b00;
                            r_forb2 <= 2'b00;
                        end
                        default: begin
                            if (r_invalid != C_SAT) r_invalid <= r_invalid + 5'd1;
                        end
                    endcase
                    // A decided match wins over the round limit on the same cycle.
                    if (PARTITA != 2'b00) begin
                        r_result <= PARTITA;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (r_round == C_LAST_ROUND) begin
                        r_timeout <= 1'b1;
                        r_result  <= 2'b00;
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign INIZIA       = r_inizia;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign match_result = r_result;
    assign wins1        = r_wins1;
    assign wins2        = r_wins2;
    assign draws        = r_draws;
    assign invalid      = r_invalid;

endmodule
`default_nettype wire
